// File: rtl/cpld_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpld_uart_bridge
// Purpose  : valid/ready byte streams <-> CPLD UART rdn/wrn strobes on the
//            shared low byte of the BaseRAM data bus. Optional macro
//            CPLD_UART_RX_FIFO_EN selects a 4-entry rx FIFO.
// Revision : 1.0  initial release
// ============================================================================
module cpld_uart_bridge #(
  parameter int RD_PULSE = 3,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 3,
  parameter int WR_HOLD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       uart_rdn,
  output logic       uart_wrn,
  input  logic       uart_dataready,
  input  logic       uart_tbre,
  input  logic       uart_tsre,
  input  logic [7:0] bus_d_i,
  output logic [7:0] bus_d_o,
  output logic       bus_d_oe,
  output logic       bus_busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(RD_PULSE - 1);
  localparam logic [CNT_W-1:0] C_WS_LAST = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] C_WP_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] C_WH_LAST = CNT_W'(WR_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_STROBE  = 3'd1,
    WR_SETUP_S = 3'd2,
    WR_STROBE  = 3'd3,
    WR_HOLD_S  = 3'd4,
    WAIT_TBRE  = 3'd5,
    WAIT_TSRE  = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [1:0]       r_up;
  logic             w_dataready;
  logic             w_tbre;
  logic             w_tsre;
  logic             w_rx_free;
  logic             w_rx_win;
  logic             w_push;

  // r_up holds off arbitration until the synchronisers carry real samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_up    <= '0;
    end else begin
      r_sync1 <= {uart_tsre, uart_tbre, uart_dataready};
      r_sync2 <= r_sync1;
      r_up    <= {r_up[0], 1'b1};
    end
  end

  assign w_dataready = r_sync2[0];
  assign w_tbre      = r_sync2[1];
  assign w_tsre      = r_sync2[2];

  assign w_rx_win = r_up[1] && (r_state == IDLE) && w_dataready && w_rx_free;
  assign tx_ready = r_up[1] && (r_state == IDLE) && !w_rx_win;
  assign w_push   = (r_state == RD_STROBE) && (r_cnt == C_RD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      uart_rdn <= 1'b1;
      uart_wrn <= 1'b1;
      bus_d_oe <= 1'b0;
      bus_d_o  <= '0;
      bus_busy <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_rx_win) begin
            r_state  <= RD_STROBE;
            uart_rdn <= 1'b0;
            bus_busy <= 1'b1;
          end else if (tx_valid && tx_ready) begin
            r_state  <= WR_SETUP_S;
            bus_d_o  <= tx_data;
            bus_d_oe <= 1'b1;
            bus_busy <= 1'b1;
          end
        end
        RD_STROBE: begin
          if (r_cnt == C_RD_LAST) begin
            r_state  <= IDLE;
            uart_rdn <= 1'b1;
            bus_busy <= 1'b0;
          end
        end
        WR_SETUP_S: begin
          if (r_cnt == C_WS_LAST) begin
            r_cnt    <= '0;
            r_state  <= WR_STROBE;
            uart_wrn <= 1'b0;
          end
        end
        WR_STROBE: begin
          if (r_cnt == C_WP_LAST) begin
            r_cnt    <= '0;
            r_state  <= WR_HOLD_S;
            uart_wrn <= 1'b1;
          end
        end
        WR_HOLD_S: begin
          if (r_cnt == C_WH_LAST) begin
            r_state  <= WAIT_TBRE;
            bus_d_oe <= 1'b0;
            bus_busy <= 1'b0;
          end
        end
        WAIT_TBRE: begin
          r_cnt <= '0;
          if (w_tbre) r_state <= WAIT_TSRE;
        end
        WAIT_TSRE: begin
          r_cnt <= '0;
          if (w_tsre) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CPLD_UART_RX_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic       r_full;
  logic       r_empty;
  logic       w_pop;

  assign w_pop     = !r_empty && rx_ready;
  assign rx_valid  = !r_empty;
  assign rx_data   = r_mem[r_rd_ptr];
  assign w_rx_free = !r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus_d_i;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      // push and pop together leave occupancy unchanged
      if (w_push && !w_pop) begin
        r_empty <= 1'b0;
        r_full  <= ((r_wr_ptr + 2'd1) == r_rd_ptr);
      end else if (w_pop && !w_push) begin
        r_full  <= 1'b0;
        r_empty <= ((r_rd_ptr + 2'd1) == r_wr_ptr);
      end
    end
  end
`else
  assign w_rx_free = !rx_valid || rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (w_push) begin
      rx_data  <= bus_d_i;
      rx_valid <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire
